// File: rtl/out_channel.sv
// out_channel: single-clock element channel with EMPTY/PARTIAL/FULL tracking.
// Ring mode (OVERWRITE=1) drops the oldest element when written while full.
// Backpressure mode (OVERWRITE=0) deasserts in_ready while full.
// Optional statistics ports (writes, drops) exist only when the macro
// OUT_CHANNEL_STATS_EN is defined; the default build omits them entirely.
//
// state   | meaning
// --------+-------------------------------------------------
// EMPTY   | no elements held, out_valid low
// PARTIAL | 1..DEPTH-1 elements held
// FULL    | DEPTH elements held; ring writes drop the oldest
module out_channel #(
  parameter int WIDTH     = 12,
  parameter int DEPTH     = 5,
  parameter int OVERWRITE = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
`ifdef OUT_CHANNEL_STATS_EN
  ,
  output logic [31:0]                writes,
  output logic [31:0]                drops
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LastIdx   = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  // Reject unsupported geometries at elaboration rather than building a broken channel.
  if (DEPTH < 2 || DEPTH > 256) begin : gBadDepth
    $error("out_channel: DEPTH must be in 2..256");
  end
  if (OVERWRITE != 0 && OVERWRITE != 1) begin : gBadMode
    $error("out_channel: OVERWRITE must be 0 or 1");
  end

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } stateT;

  stateT            state;
  stateT            nextState;
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic [CW-1:0]    nextCount;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             wrEn;
  logic             rdEn;
  logic             dropEn;

  // Pointers wrap by explicit compare so any DEPTH works, not just powers of two.
  function automatic logic [PW-1:0] wrapInc(input logic [PW-1:0] ptr);
    return (ptr == LastIdx) ? '0 : ptr + PW'(1);
  endfunction

  // Handshakes: in_ready/out_valid come from the state register only, so
  // there is no combinational path from out_ready to in_ready.
  always_comb begin
    wrEn   = in_valid && in_ready;
    rdEn   = out_valid && out_ready;
    dropEn = wrEn && !rdEn && (state == FULL);
  end

  // Occupancy after this cycle's transfers; a ring drop keeps the count at DEPTH.
  always_comb begin
    nextCount = count;
    unique case ({wrEn, rdEn})
      2'b10:   nextCount = dropEn ? count : count + CW'(1);
      2'b01:   nextCount = count - CW'(1);
      default: nextCount = count;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= nextState;
    end
  end

  // FSM next state, derived from the post-transfer occupancy; flush wins.
  always_comb begin
    nextState = state;
    if (flush) begin
      nextState = EMPTY;
    end else if (nextCount == '0) begin
      nextState = EMPTY;
    end else if (nextCount == FullCount) begin
      nextState = FULL;
    end else begin
      nextState = PARTIAL;
    end
  end

  // FSM outputs, decoded from registers only.
  always_comb begin
    out_valid = (state != EMPTY);
    in_ready  = (OVERWRITE != 0) ? 1'b1 : (state != FULL);
    out_data  = mem[rdPtr];
  end

  // Pointers, occupancy and sticky overflow; flush clears them but not memory.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wrEn) begin
        wrPtr <= wrapInc(wrPtr);
      end
      if (rdEn || dropEn) begin
        rdPtr <= wrapInc(rdPtr);
      end
      count <= nextCount;
      if (dropEn) begin
        overflow <= 1'b1;
      end
    end
  end

  // Element storage; never reset, and a write flushed or under reset is discarded.
  always_ff @(posedge clock) begin
    if (reset && wrEn && !flush) begin
      mem[wrPtr] <= in_data;
    end
  end

`ifdef OUT_CHANNEL_STATS_EN
  // Saturating counters of completed writes and ring-mode drops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      writes <= '0;
      drops  <= '0;
    end else if (flush) begin
      writes <= '0;
      drops  <= '0;
    end else begin
      if (wrEn && (writes != '1)) begin
        writes <= writes + 32'd1;
      end
      if (dropEn && (drops != '1)) begin
        drops <= drops + 32'd1;
      end
    end
  end
`endif

endmodule
